// File: rtl/hsm_pkg.sv
// +------------------------------------------------------------------+
// | hsm_pkg                                                          |
// | Shared types and helpers for the handshake stability monitor.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package hsm_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } hsm_state_e;

  typedef struct packed {
    logic drop;
    logic change;
    logic timeout;
  } hsm_viol_t;

  // Width of the stall-run counter; never narrower than one bit.
  function automatic int unsigned run_width(input int unsigned max_stall);
    return (max_stall == 0) ? 1 : $clog2(max_stall + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +------------------------------------------------------------------+
// | sat_counter                                                      |
// | Up-counter that sticks at all-ones; synchronous clear wins.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else if (clear_i) begin
      r_q <= '0;
    end else if (en_i && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q_o = r_q;

endmodule

`default_nettype wire

// File: rtl/handshake_stability_monitor.sv
// +------------------------------------------------------------------+
// | handshake_stability_monitor                                      |
// | Passive valid/ready checker: stall stability, timeout, counters. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module handshake_stability_monitor
  import hsm_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned CntWidth       = 32,
  parameter int unsigned MaxStallCycles = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 valid_i,
  input  logic                 ready_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [CntWidth-1:0]  hs_count_o,
  output logic [CntWidth-1:0]  stall_count_o,
  output logic                 err_drop_o,
  output logic                 err_change_o,
  output logic                 err_timeout_o,
  output logic                 error_o,
  output logic                 viol_o
);

  localparam int unsigned c_run_width = run_width(MaxStallCycles);
  localparam logic [c_run_width-1:0] c_run_max = c_run_width'(MaxStallCycles);

  hsm_state_e             r_state;
  hsm_state_e             w_state_next;
  logic [DataWidth-1:0]   r_held;
  logic [c_run_width-1:0] w_run;
  hsm_viol_t              w_new;
  logic                   w_hs;
  logic                   w_stall;
  logic                   w_capture;
  logic                   w_timeout_hit;
  logic                   r_err_drop;
  logic                   r_err_change;
  logic                   r_err_timeout;
  logic                   r_viol;

  assign w_hs    = valid_i & ready_i;
  assign w_stall = valid_i & ~ready_i;

  sat_counter #(.Width(CntWidth)) u_hs_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (w_hs),
    .q_o     (hs_count_o)
  );

  sat_counter #(.Width(CntWidth)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (w_stall),
    .q_o     (stall_count_o)
  );

  // Run length restarts on any non-stall cycle, so a fresh offer from IDLE lands on 1.
  sat_counter #(.Width(c_run_width)) u_run_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i | ~w_stall),
    .en_i    (w_stall & (w_run != c_run_max)),
    .q_o     (w_run)
  );

  generate
    if (MaxStallCycles != 0) begin : g_timeout
      localparam logic [c_run_width-1:0] c_run_trig = c_run_width'(MaxStallCycles - 1);
      assign w_timeout_hit = w_stall & (w_run == c_run_trig);
    end else begin : g_no_timeout
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else if (clear_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_capture      = 1'b0;
    w_new          = '0;
    unique case (r_state)
      IDLE: begin
        if (w_stall) begin
          w_capture    = 1'b1;
          w_state_next = PEND;
        end
      end
      PEND: begin
        if (!valid_i) begin
          w_new.drop   = 1'b1;
          w_state_next = IDLE;
        end else begin
          // A changed beat is still tracked: recapture it unless it is accepted now.
          if (data_i != r_held) begin
            w_new.change = 1'b1;
            w_capture    = ~ready_i;
          end
          if (ready_i) begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_new.timeout = w_timeout_hit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_held        <= '0;
      r_err_drop    <= 1'b0;
      r_err_change  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_viol        <= 1'b0;
    end else if (clear_i) begin
      r_err_drop    <= 1'b0;
      r_err_change  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_viol        <= 1'b0;
    end else begin
      if (w_capture) begin
        r_held <= data_i;
      end
      r_err_drop    <= r_err_drop    | w_new.drop;
      r_err_change  <= r_err_change  | w_new.change;
      r_err_timeout <= r_err_timeout | w_new.timeout;
      r_viol        <= |w_new;
    end
  end

  assign err_drop_o    = r_err_drop;
  assign err_change_o  = r_err_change;
  assign err_timeout_o = r_err_timeout;
  assign error_o       = r_err_drop | r_err_change | r_err_timeout;
  assign viol_o        = r_viol;

endmodule

`default_nettype wire
